// File: rtl/tdd_burst_capture_pkg.sv
// Shared types and sizing for the TDD burst capture path.
// Entry layout is {last, I, Q}.
package tdd_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  function automatic int entry_width(input int dw);
    return 2 * dw + 1;
  endfunction

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/tdd_burst_capture_if.sv
// Valid/ready beat stream carrying framed I/Q samples.
// The master drives beats; the slave drives ready.
interface tdd_burst_capture_if
  import tdd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic [DATA_WIDTH-1:0] m_data_I;
  logic [DATA_WIDTH-1:0] m_data_Q;

  modport master (
    output m_valid,
    output m_last,
    output m_data_I,
    output m_data_Q,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_last,
    input  m_data_I,
    input  m_data_Q,
    output m_ready
  );

endinterface

// File: rtl/tdd_sample_fifo.sv
// Single-clock FIFO with extra pointer MSB for full/empty.
// Head is read combinationally and reads zero when empty.
module tdd_sample_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO still takes a push when the head leaves this cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both advance on a concurrent push and pop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tdd_burst_capture.sv
// Frames each high sync_in window into a burst of beats.
// One-sample hold delays data so the final beat can carry last.
module tdd_burst_capture
  import tdd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sync_in,
  input  logic [DATA_WIDTH-1:0] data_in_I,
  input  logic [DATA_WIDTH-1:0] data_in_Q,
  tdd_burst_capture_if.master   stream,
  output logic                  overflow,
  output logic [15:0]           burst_count
);

  localparam int EW = entry_width(DATA_WIDTH);

  state_t                state;
  logic [DATA_WIDTH-1:0] hold_i;
  logic [DATA_WIDTH-1:0] hold_q;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          accept;
  logic          drop;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head;

  // A held sample is pushed every cycle; sync_in low marks it last.
  assign push      = (state == ACTIVE);
  assign push_data = {~sync_in, hold_i, hold_q};
  assign pop       = ~empty & stream.m_ready;
  assign accept    = push & (~full | pop);
  assign drop      = push & full & ~pop;

  tdd_sample_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .pop_data  (head)
  );

  assign stream.m_valid  = ~empty;
  assign stream.m_last   = head[EW-1];
  assign stream.m_data_I = head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign stream.m_data_Q = head[DATA_WIDTH-1:0];

  // Hold-register FSM: IDLE means empty hold, ACTIVE means full.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      hold_i <= '0;
      hold_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sync_in) begin
            hold_i <= data_in_I;
            hold_q <= data_in_Q;
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (sync_in) begin
            hold_i <= data_in_I;
            hold_q <= data_in_Q;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky drop flag and count of bursts closed in the FIFO.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow    <= 1'b0;
      burst_count <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (accept && !sync_in) burst_count <= burst_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tdd_burst_capture.sv
// Directed bench for tdd_burst_capture.
// Beats are collected at negedge and compared to hand-built lists.
module tb_tdd_burst_capture;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sync_in;
  logic [15:0] di;
  logic [15:0] dq;
  logic        overflow;
  logic [15:0] burst_count;

  int checks = 0;
  int errors = 0;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  tdd_burst_capture_if #(.DATA_WIDTH(16)) bus ();

  tdd_burst_capture #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sync_in     (sync_in),
    .data_in_I   (di),
    .data_in_Q   (dq),
    .stream      (bus.master),
    .overflow    (overflow),
    .burst_count (burst_count)
  );

  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1)
      got_q.push_back({bus.m_last, bus.m_data_I, bus.m_data_Q});
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [15:0] i,
                       input logic [15:0] q);
    sync_in = s;
    di      = i;
    dq      = q;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset(input logic rdy);
    rstn        = 1'b0;
    sync_in     = 1'b0;
    di          = '0;
    dq          = '0;
    bus.m_ready = rdy;
    tick();
    tick();
    rstn = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_n"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 64'(bus.m_valid), 64'd0);
    chk({tag, "_last"}, 64'(bus.m_last), 64'd0);
    chk({tag, "_i"}, 64'(bus.m_data_I), 64'd0);
    chk({tag, "_q"}, 64'(bus.m_data_Q), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_bc"}, 64'(burst_count), 64'd0);
  endtask

  initial begin
    rstn        = 1'b0;
    sync_in     = 1'b0;
    di          = '0;
    dq          = '0;
    bus.m_ready = 1'b0;
    repeat (3) tick();
    check_reset("rst");

    // 3-sample window, checks first-beat latency
    do_reset(1'b1);
    drive(1'b1, 16'd1, 16'hFFFF);
    chk("t1_lat_n1", 64'(bus.m_valid), 64'd0);
    drive(1'b1, 16'd2, 16'hFFFE);
    chk("t1_lat_n2", 64'(bus.m_valid), 64'd1);
    chk("t1_head", 64'(bus.m_data_I), 64'd1);
    drive(1'b1, 16'd3, 16'hFFFD);
    idle(6);
    exp_q.push_back({1'b0, 16'd1, 16'hFFFF});
    exp_q.push_back({1'b0, 16'd2, 16'hFFFE});
    exp_q.push_back({1'b1, 16'd3, 16'hFFFD});
    check_beats("t1");
    chk("t1_bc", 64'(burst_count), 64'd1);

    // single-cycle window
    do_reset(1'b1);
    drive(1'b1, 16'h7FFF, 16'h1234);
    idle(5);
    exp_q.push_back({1'b1, 16'h7FFF, 16'h1234});
    check_beats("t2");
    chk("t2_bc", 64'(burst_count), 64'd1);

    // two 2-sample windows with a single low gap
    do_reset(1'b1);
    drive(1'b1, 16'd1, 16'hA1);
    drive(1'b1, 16'd2, 16'hA2);
    drive(1'b0, 16'd0, 16'h0);
    drive(1'b1, 16'd3, 16'hA3);
    drive(1'b1, 16'd4, 16'hA4);
    idle(6);
    exp_q.push_back({1'b0, 16'd1, 16'hA1});
    exp_q.push_back({1'b1, 16'd2, 16'hA2});
    exp_q.push_back({1'b0, 16'd3, 16'hA3});
    exp_q.push_back({1'b1, 16'd4, 16'hA4});
    check_beats("t3");
    chk("t3_bc", 64'(burst_count), 64'd2);

    // 20 samples into a stalled depth-16 FIFO
    do_reset(1'b0);
    for (int k = 1; k <= 20; k++)
      drive(1'b1, 16'(k), 16'(k + 100));
    idle(2);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_bc", 64'(burst_count), 64'd0);
    chk("t4_valid", 64'(bus.m_valid), 64'd1);
    chk("t4_head_i", 64'(bus.m_data_I), 64'd1);
    chk("t4_head_last", 64'(bus.m_last), 64'd0);
    chk("t4_nopop", 64'(got_q.size()), 64'd0);
    bus.m_ready = 1'b1;
    idle(20);
    for (int k = 1; k <= 16; k++)
      exp_q.push_back({1'b0, 16'(k), 16'(k + 100)});
    check_beats("t4");
    chk("t4_drained", 64'(bus.m_valid), 64'd0);
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);

    // full FIFO with pop and push on the same cycles
    do_reset(1'b0);
    for (int k = 1; k <= 17; k++)
      drive(1'b1, 16'(k), 16'(k + 200));
    bus.m_ready = 1'b1;
    drive(1'b1, 16'd18, 16'd218);
    chk("t5_head", 64'(bus.m_data_I), 64'd2);
    chk("t5_ovf_mid", 64'(overflow), 64'd0);
    drive(1'b1, 16'd19, 16'd219);
    drive(1'b1, 16'd20, 16'd220);
    idle(25);
    for (int k = 1; k <= 20; k++)
      exp_q.push_back({k == 20, 16'(k), 16'(k + 200)});
    check_beats("t5");
    chk("t5_ovf", 64'(overflow), 64'd0);
    chk("t5_bc", 64'(burst_count), 64'd1);

    // one-cycle reset in the middle of a window
    do_reset(1'b1);
    for (int k = 1; k <= 4; k++)
      drive(1'b1, 16'(k), 16'(k + 300));
    rstn = 1'b0;
    drive(1'b1, 16'd5, 16'd305);
    check_reset("t6_rst");
    got_q.delete();
    rstn = 1'b1;
    drive(1'b1, 16'd6, 16'd306);
    drive(1'b1, 16'd7, 16'd307);
    drive(1'b1, 16'd8, 16'd308);
    idle(6);
    exp_q.push_back({1'b0, 16'd6, 16'd306});
    exp_q.push_back({1'b0, 16'd7, 16'd307});
    exp_q.push_back({1'b1, 16'd8, 16'd308});
    check_beats("t6");
    chk("t6_bc", 64'(burst_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdd_burst_capture.md
# tdd_burst_capture

Receive-side counterpart of the TDD sync gate. It takes the gated I/Q sample stream and its window qualifier `sync_in`, and frames every contiguous high window into a packet. Packets are buffered in a small FIFO and presented on a valid/ready stream with an end-of-burst marker. It sits between the TDD gating stage and any downstream DMA/packetizer that needs burst boundaries rather than zero-filled gaps.

## Interface
- `DATA_WIDTH`, 16, width of each I and Q sample
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `clk`  in  1  sole clock; all logic rising-edge
- `rstn`  in  1  synchronous, active-low reset
- `sync_in`  in  1  window qualifier; sample valid on every cycle it is high
- `data_in_I`  in  DATA_WIDTH  I sample
- `data_in_Q`  in  DATA_WIDTH  Q sample
- `m_valid`  out  1  output beat available
- `m_ready`  in  1  downstream accepts beat
- `m_data_I`  out  DATA_WIDTH  I of head entry
- `m_data_Q`  out  DATA_WIDTH  Q of head entry
- `m_last`  out  1  head entry is final sample of its window
- `overflow`  out  1  sticky; a sample was dropped on a full FIFO
- `burst_count`  out  16  number of last-flagged entries written; wraps at 2^16

## Operation
- One-sample hold register `{I,Q}` plus a hold-valid bit gives a two-state FSM:
  - IDLE: hold empty.
  - ACTIVE: hold full.
- IDLE, `sync_in`=1: load hold, go ACTIVE. `sync_in`=0: stay.
- ACTIVE, `sync_in`=1: push hold with last=0, reload hold, stay ACTIVE.
- ACTIVE, `sync_in`=0: push hold with last=1, go IDLE.
- No rising edge is required. Capture starts on any cycle with `sync_in`=1, including the first cycle after reset.
- FIFO entry is `{last, I, Q}` (2·DATA_WIDTH+1 bits). Head entry is read combinationally. `m_valid` = not empty.
- Pop happens when `m_valid && m_ready`.
- Push is accepted when not full, or when full and a pop occurs in the same cycle. In that case the count is unchanged and the pointers both advance.
- Push rejected (full, no pop): entry dropped and `overflow` set to 1 until reset. Framing after a drop is not guaranteed; a dropped last merges the burst with the next one.
- `burst_count` increments only when a last=1 entry is actually written.
- Pointers are log2(FIFO_DEPTH)+1 bits. Full/empty are derived from the MSB compare and wrap naturally.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `m_data_I/Q`=0 (empty FIFO reads zero), `overflow`=0, `burst_count`=0, FSM IDLE, pointers 0.
- Reset mid-burst: hold and FIFO contents discarded, no last emitted. The next high `sync_in` cycle after `rstn` rises starts a new burst.
- Latency:
  - Sample present in cycle N is captured at end of N.
  - It is pushed at end of N+1.
  - `m_valid` is high in cycle N+2 if the FIFO was empty.
- The last flag is known one cycle after the final sample. The `sync_in` low cycle is consumed to close the burst.
- One-cycle window yields one beat with `m_last`=1.
- A window separated from the previous one by a single low cycle is framed correctly; no gap is required beyond that one cycle.
- Downstream must hold nothing stable; `m_data_*`/`m_last` change only on pop or on a push into an empty FIFO.

## Structure
- Package `tdd_pkg`:
  - default `DATA_WIDTH`
  - function for entry width
  - FSM state enum {IDLE, ACTIVE}
- Sub-module `tdd_sample_fifo`:
  - synchronous single-clock FIFO, parameters width/depth
  - ports: push/pop/full/empty/data
  - same `clk`/`rstn`
- Top level holds the FSM, hold register, `overflow` and `burst_count`.

## Test plan
- Window of 3 cycles (I=1,2,3; Q=−1,−2,−3), `m_ready`=1:
  - 3 beats, first `m_valid` 2 cycles after the first sample.
  - `m_last` only on I=3.
  - `burst_count`=1.
- Single-cycle window I=0x7FFF: one beat with `m_last`=1; `burst_count`=1.
- Windows of 2 and 2 samples separated by one low cycle: beats 2+2 with `m_last` on the 2nd and 4th; `burst_count`=2.
- `m_ready`=0, 20-sample window, depth 16:
  - FIFO holds I=1..16; 17..20 dropped.
  - `overflow`=1, no `m_last`, `burst_count`=0.
  - After draining, 16 beats come out in order.
- FIFO full with `m_ready`=1 and concurrent push on the same cycle: both accepted, count stays 16, no overflow.
- `rstn` low for 1 cycle mid-window (after 4 samples), `sync_in` kept high:
  - All outputs return to reset values.
  - The post-reset samples form a new burst with the correct `m_last`.
